// File: rtl/gcd_rr_scheduler.sv
// Shared subtractive GCD engine with a round-robin front end.
// One job at a time: grant in IDLE, subtract loop in RUN, hold result in DONE.
module gcd_rr_scheduler #(
  parameter int WIDTH = 16,
  parameter int NREQ  = 4,
  parameter int IDW   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] a_in,
  input  logic [NREQ*WIDTH-1:0] b_in,
  output logic [NREQ-1:0]       gnt,
  output logic                  busy,
  output logic                  res_valid,
  output logic [WIDTH-1:0]      res_data,
  output logic [IDW-1:0]        res_id,
  output logic [WIDTH-1:0]      res_iters,
  input  logic                  res_ready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] iters_q, iters_d, iters_inc_s;
  logic [WIDTH-1:0] res_data_q, res_data_d, res_iters_q, res_iters_d;
  logic [WIDTH-1:0] a_sel_s, b_sel_s;
  logic [IDW-1:0]   id_q, id_d, last_q, last_d, res_id_q, res_id_d, sel_s;
  logic             res_valid_q, res_valid_d, busy_q, busy_d, found_s;
  logic [NREQ-1:0]  gnt_s;

  // Requester index reached by stepping 'off' places past 'base', wrapping at NREQ.
  function automatic logic [IDW-1:0] rr_index(input logic [IDW-1:0] base, input int off);
    int t;
    t = (int'(base) + off) % NREQ;
    return IDW'(t);
  endfunction

  // Round-robin search: first asserted req after the last granted index.
  always_comb begin
    found_s = 1'b0;
    sel_s   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!found_s && req[rr_index(last_q, k)]) begin
        found_s = 1'b1;
        sel_s   = rr_index(last_q, k);
      end else begin
        found_s = found_s;
      end
    end
  end

  // Operand mux for the selected requester.
  always_comb begin
    a_sel_s = '0;
    b_sel_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (sel_s == IDW'(i)) begin
        a_sel_s = a_in[i*WIDTH +: WIDTH];
        b_sel_s = b_in[i*WIDTH +: WIDTH];
      end else begin
        a_sel_s = a_sel_s;
        b_sel_s = b_sel_s;
      end
    end
  end

  // Grant pulse only while idle; forced low while reset is held.
  always_comb begin
    gnt_s = '0;
    if (rst_n && (state_q == IDLE) && found_s) begin
      gnt_s = NREQ'(1'b1) << sel_s;
    end else begin
      gnt_s = '0;
    end
  end

  // Saturating per-job cycle counter value for this RUN cycle.
  always_comb begin
    iters_inc_s = iters_q;
    if (&iters_q) begin
      iters_inc_s = iters_q;
    end else begin
      iters_inc_s = iters_q + WIDTH'(1'b1);
    end
  end

  // Next-state and datapath updates for the IDLE/RUN/DONE sequence.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    id_d        = id_q;
    last_d      = last_q;
    iters_d     = iters_q;
    res_data_d  = res_data_q;
    res_id_d    = res_id_q;
    res_iters_d = res_iters_q;
    res_valid_d = res_valid_q;
    case (state_q)
      IDLE: begin
        if (found_s) begin
          a_d     = a_sel_s;
          b_d     = b_sel_s;
          id_d    = sel_s;
          last_d  = sel_s;
          iters_d = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        iters_d = iters_inc_s;
        if ((a_q == b_q) || (b_q == '0)) begin
          res_data_d  = a_q;
          res_id_d    = id_q;
          res_iters_d = iters_inc_s;
          res_valid_d = 1'b1;
          state_d     = DONE;
        end else if (a_q == '0) begin
          res_data_d  = b_q;
          res_id_d    = id_q;
          res_iters_d = iters_inc_s;
          res_valid_d = 1'b1;
          state_d     = DONE;
        end else if (a_q > b_q) begin
          a_d = a_q - b_q;
        end else begin
          b_d = b_q - a_q;
        end
      end
      DONE: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end else begin
          res_valid_d = 1'b1;
        end
      end
      default: begin
        res_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and datapath registers; reset abandons any job in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      id_q        <= '0;
      last_q      <= IDW'(NREQ - 1);
      iters_q     <= '0;
      res_data_q  <= '0;
      res_id_q    <= '0;
      res_iters_q <= '0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      id_q        <= id_d;
      last_q      <= last_d;
      iters_q     <= iters_d;
      res_data_q  <= res_data_d;
      res_id_q    <= res_id_d;
      res_iters_q <= res_iters_d;
      res_valid_q <= res_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign gnt       = gnt_s;
  assign busy      = busy_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_id    = res_id_q;
  assign res_iters = res_iters_q;

endmodule
